// File: rtl/dequant_zigzag_writer_pkg.sv
// Shared types, address map and dequantization shift tables for the
// zig-zag dequant writer feeding the pre-IDCT SRAM region.
package dequant_zigzag_writer_pkg;

   typedef enum logic [1:0] {
      S_DZ_IDLE      = 2'd0,
      S_DZ_ACCEPT    = 2'd1,
      S_DZ_BLOCK_END = 2'd2,
      S_DZ_DONE      = 2'd3
   } dz_state_e;

   typedef enum logic [1:0] {
      SEG_Y = 2'd0,
      SEG_U = 2'd1,
      SEG_V = 2'd2
   } dz_seg_e;

   localparam logic [17:0] PRE_IDCT_BASE_C = 18'd76800;
   localparam logic [17:0] U_SEG_BASE_C    = 18'd153600;
   localparam logic [17:0] V_SEG_BASE_C    = 18'd192000;
   localparam logic [17:0] Y_STRIDE_C      = 18'd320;
   localparam logic [17:0] UV_STRIDE_C     = 18'd160;
   localparam int          Y_BLOCKS_X_C    = 40;
   localparam int          UV_BLOCKS_X_C   = 20;
   localparam int          BLOCK_ROWS_C    = 30;
   localparam int          Y_BLOCKS_C      = Y_BLOCKS_X_C * BLOCK_ROWS_C;
   localparam int          UV_BLOCKS_C     = UV_BLOCKS_X_C * BLOCK_ROWS_C;

   // Left-shift amount indexed by anti-diagonal s = r + c; q_sel picks the table.
   function automatic logic [2:0] dq_shift(input logic q_sel, input logic [3:0] s);
      logic [2:0] sh;
      sh = 3'd0;
      if (q_sel == 1'b0) begin
         case (s)
            4'd0:    sh = 3'd3;
            4'd1:    sh = 3'd2;
            4'd2:    sh = 3'd3;
            4'd3:    sh = 3'd4;
            4'd4:    sh = 3'd4;
            4'd5:    sh = 3'd5;
            4'd6:    sh = 3'd5;
            default: sh = 3'd6;
         endcase
      end else begin
         case (s)
            4'd0:    sh = 3'd3;
            4'd1:    sh = 3'd1;
            4'd2:    sh = 3'd1;
            4'd3:    sh = 3'd1;
            4'd4:    sh = 3'd2;
            4'd5:    sh = 3'd2;
            4'd6:    sh = 3'd3;
            4'd7:    sh = 3'd3;
            default: sh = 3'd4;
         endcase
      end
      return sh;
   endfunction

endpackage

// File: rtl/dequant_zigzag_writer_zigzag_rom.sv
// Standard JPEG zig-zag scan index to (row, column) lookup.
// Entries are octal pairs: first digit row, second digit column.
module zigzag_rom
   import dequant_zigzag_writer_pkg::*;
(
   input  logic [5:0] k,
   output logic [2:0] r,
   output logic [2:0] c
);

   logic [5:0] rc_s;

   // Scan position decode
   always_comb begin
      rc_s = 6'o00;
      case (k)
         6'd0:  rc_s = 6'o00;  6'd1:  rc_s = 6'o01;  6'd2:  rc_s = 6'o10;  6'd3:  rc_s = 6'o20;
         6'd4:  rc_s = 6'o11;  6'd5:  rc_s = 6'o02;  6'd6:  rc_s = 6'o03;  6'd7:  rc_s = 6'o12;
         6'd8:  rc_s = 6'o21;  6'd9:  rc_s = 6'o30;  6'd10: rc_s = 6'o40;  6'd11: rc_s = 6'o31;
         6'd12: rc_s = 6'o22;  6'd13: rc_s = 6'o13;  6'd14: rc_s = 6'o04;  6'd15: rc_s = 6'o05;
         6'd16: rc_s = 6'o14;  6'd17: rc_s = 6'o23;  6'd18: rc_s = 6'o32;  6'd19: rc_s = 6'o41;
         6'd20: rc_s = 6'o50;  6'd21: rc_s = 6'o60;  6'd22: rc_s = 6'o51;  6'd23: rc_s = 6'o42;
         6'd24: rc_s = 6'o33;  6'd25: rc_s = 6'o24;  6'd26: rc_s = 6'o15;  6'd27: rc_s = 6'o06;
         6'd28: rc_s = 6'o07;  6'd29: rc_s = 6'o16;  6'd30: rc_s = 6'o25;  6'd31: rc_s = 6'o34;
         6'd32: rc_s = 6'o43;  6'd33: rc_s = 6'o52;  6'd34: rc_s = 6'o61;  6'd35: rc_s = 6'o70;
         6'd36: rc_s = 6'o71;  6'd37: rc_s = 6'o62;  6'd38: rc_s = 6'o53;  6'd39: rc_s = 6'o44;
         6'd40: rc_s = 6'o35;  6'd41: rc_s = 6'o26;  6'd42: rc_s = 6'o17;  6'd43: rc_s = 6'o27;
         6'd44: rc_s = 6'o36;  6'd45: rc_s = 6'o45;  6'd46: rc_s = 6'o54;  6'd47: rc_s = 6'o63;
         6'd48: rc_s = 6'o72;  6'd49: rc_s = 6'o73;  6'd50: rc_s = 6'o64;  6'd51: rc_s = 6'o55;
         6'd52: rc_s = 6'o46;  6'd53: rc_s = 6'o37;  6'd54: rc_s = 6'o47;  6'd55: rc_s = 6'o56;
         6'd56: rc_s = 6'o65;  6'd57: rc_s = 6'o74;  6'd58: rc_s = 6'o75;  6'd59: rc_s = 6'o66;
         6'd60: rc_s = 6'o57;  6'd61: rc_s = 6'o67;  6'd62: rc_s = 6'o76;  6'd63: rc_s = 6'o77;
         default: rc_s = 6'o00;
      endcase
   end

   assign r = rc_s[5:3];
   assign c = rc_s[2:0];

endmodule

// File: rtl/dequant_zigzag_writer.sv
// Dequantizes zig-zag ordered 8x8 coefficient blocks and writes them in raster
// order into the Y, U and V pre-IDCT SRAM segments.
module dequant_zigzag_writer
   import dequant_zigzag_writer_pkg::*;
#(
   parameter logic [17:0] PRE_IDCT_BASE = PRE_IDCT_BASE_C,
   parameter logic [17:0] U_SEG_BASE    = U_SEG_BASE_C,
   parameter logic [17:0] V_SEG_BASE    = V_SEG_BASE_C,
   parameter logic [17:0] Y_STRIDE      = Y_STRIDE_C,
   parameter logic [17:0] UV_STRIDE     = UV_STRIDE_C,
   parameter int          Y_BLOCKS_X    = Y_BLOCKS_X_C,
   parameter int          UV_BLOCKS_X   = UV_BLOCKS_X_C,
   parameter int          BLOCK_ROWS    = BLOCK_ROWS_C
)(
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Enable,
   input  logic        Q_select,
   input  logic        coeff_valid,
   input  logic [15:0] coeff_data,
   output logic        coeff_ready,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        block_done,
   output logic        done
);

   localparam int TOTAL_BLOCKS = (Y_BLOCKS_X + 2 * UV_BLOCKS_X) * BLOCK_ROWS;

   dz_state_e   state_r, state_next_s;
   dz_seg_e     seg_r;
   logic [5:0]  k_r, bx_r;
   logic [4:0]  by_r;
   logic [11:0] blk_cnt_r;
   logic [17:0] blk_base_r, row_base_r;
   logic        q_sel_r;

   logic        xfer_s, last_blk_s, bx_last_s, by_last_s, q_eff_s;
   logic [2:0]  zz_r_s, zz_c_s, shift_s;
   logic [17:0] stride_s, row_step_s, next_seg_base_s, addr_s;
   logic [15:0] deq_s;

   zigzag_rom u_zigzag_rom (
      .k (k_r),
      .r (zz_r_s),
      .c (zz_c_s)
   );

   // Handshake, block position decode and dequantized write word
   always_comb begin
      xfer_s          = coeff_valid && coeff_ready;
      last_blk_s      = (blk_cnt_r == 12'(TOTAL_BLOCKS - 1));
      by_last_s       = (by_r == 5'(BLOCK_ROWS - 1));
      stride_s        = (seg_r == SEG_Y) ? Y_STRIDE : UV_STRIDE;
      bx_last_s       = (seg_r == SEG_Y) ? (bx_r == 6'(Y_BLOCKS_X - 1))
                                         : (bx_r == 6'(UV_BLOCKS_X - 1));
      row_step_s      = stride_s << 3;
      next_seg_base_s = (seg_r == SEG_Y) ? U_SEG_BASE : V_SEG_BASE;
      addr_s          = blk_base_r + 18'(zz_r_s) * stride_s + 18'(zz_c_s);
      // The k=0 coefficient uses the live select; later ones use the latched copy.
      q_eff_s         = (k_r == 6'd0) ? Q_select : q_sel_r;
      shift_s         = dq_shift(q_eff_s, 4'(zz_r_s) + 4'(zz_c_s));
      deq_s           = coeff_data << shift_s;
   end

   // Next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_DZ_IDLE:      state_next_s = Enable ? S_DZ_ACCEPT : S_DZ_IDLE;
         S_DZ_ACCEPT:    state_next_s = (xfer_s && (k_r == 6'd63)) ? S_DZ_BLOCK_END : S_DZ_ACCEPT;
         S_DZ_BLOCK_END: state_next_s = last_blk_s ? S_DZ_DONE : S_DZ_ACCEPT;
         S_DZ_DONE:      state_next_s = Enable ? S_DZ_DONE : S_DZ_IDLE;
         default:        state_next_s = S_DZ_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r <= S_DZ_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Registered outputs, scan index and block/segment walk
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         coeff_ready     <= 1'b0;
         done            <= 1'b0;
         block_done      <= 1'b0;
         SRAM_we_n       <= 1'b1;
         SRAM_address    <= 18'd0;
         SRAM_write_data <= 16'd0;
         k_r             <= 6'd0;
         q_sel_r         <= 1'b0;
         bx_r            <= 6'd0;
         by_r            <= 5'd0;
         seg_r           <= SEG_Y;
         blk_cnt_r       <= 12'd0;
         blk_base_r      <= PRE_IDCT_BASE;
         row_base_r      <= PRE_IDCT_BASE;
      end else begin
         coeff_ready <= (state_next_s == S_DZ_ACCEPT);
         done        <= (state_next_s == S_DZ_DONE);
         block_done  <= xfer_s && (k_r == 6'd63);
         SRAM_we_n   <= ~xfer_s;
         if (xfer_s) begin
            SRAM_address    <= addr_s;
            SRAM_write_data <= deq_s;
            k_r             <= k_r + 6'd1;
         end
         if (xfer_s && (k_r == 6'd0)) begin
            q_sel_r <= Q_select;
         end
         if (state_r == S_DZ_IDLE) begin
            k_r        <= 6'd0;
            bx_r       <= 6'd0;
            by_r       <= 5'd0;
            seg_r      <= SEG_Y;
            blk_cnt_r  <= 12'd0;
            blk_base_r <= PRE_IDCT_BASE;
            row_base_r <= PRE_IDCT_BASE;
         end else if (state_r == S_DZ_BLOCK_END) begin
            blk_cnt_r <= blk_cnt_r + 12'd1;
            if (!bx_last_s) begin
               bx_r       <= bx_r + 6'd1;
               blk_base_r <= blk_base_r + 18'd8;
            end else if (!by_last_s) begin
               bx_r       <= 6'd0;
               by_r       <= by_r + 5'd1;
               row_base_r <= row_base_r + row_step_s;
               blk_base_r <= row_base_r + row_step_s;
            end else begin
               // Segments are contiguous, but jumping to the named base keeps them independent.
               bx_r       <= 6'd0;
               by_r       <= 5'd0;
               seg_r      <= (seg_r == SEG_Y) ? SEG_U : SEG_V;
               row_base_r <= next_seg_base_s;
               blk_base_r <= next_seg_base_s;
            end
         end
      end
   end

endmodule
